// File: rtl/multicycle_control.sv
// Multi-cycle RV32I sequencer: steps each instruction through fetch, decode,
// execute, memory and write-back, with a memory-ready timeout trap and a retire counter.
//
// state   | meaning
// FETCH   | load instruction register
// DECODE  | read register bank, latch opcode, reject illegal opcodes
// EXECUTE | select ALU B operand
// MEM     | hold data-memory strobe until mem_ready or timeout
// WB      | write back result, advance PC, count retirement
// TRAP    | sticky illegal/timeout halt, left only by rst
module multicycle_control #(
   parameter int WAIT_MAX = 15,
   parameter int CNT_W    = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [6:0]       opcode,
   input  logic             mem_ready,
   output logic             pc_wr,
   output logic             ir_wr,
   output logic             reg_rd,
   output logic             reg_wr,
   output logic             mem_rd,
   output logic             mem_wr,
   output logic [1:0]       s_mux_b,
   output logic [1:0]       s_mux_c,
   output logic [2:0]       state,
   output logic             illegal,
   output logic [CNT_W-1:0] retired
);

   typedef enum logic [2:0] {
      S_FETCH   = 3'd0,
      S_DECODE  = 3'd1,
      S_EXECUTE = 3'd2,
      S_MEM     = 3'd3,
      S_WB      = 3'd4,
      S_TRAP    = 3'd5
   } state_t;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

   state_t     st, nxt_st;
   logic [6:0] op_q, nxt_op;
   logic [7:0] wait_cnt, nxt_wait;

   logic       d_pc_wr, d_ir_wr, d_reg_rd, d_reg_wr, d_mem_rd, d_mem_wr, d_illegal;
   logic [1:0] d_s_mux_b, d_s_mux_c;

   function automatic logic is_legal(input logic [6:0] op);
      return (op == OP_R) || (op == OP_I) || (op == OP_LOAD) || (op == OP_STORE);
   endfunction

   always_comb begin
      nxt_st   = st;
      nxt_op   = op_q;
      nxt_wait = wait_cnt;
      case (st)
         S_FETCH:   nxt_st = S_DECODE;
         S_DECODE: begin
            nxt_op = opcode;
            nxt_st = is_legal(opcode) ? S_EXECUTE : S_TRAP;
         end
         S_EXECUTE: begin
            nxt_wait = 8'd0;
            nxt_st   = ((op_q == OP_LOAD) || (op_q == OP_STORE)) ? S_MEM : S_WB;
         end
         S_MEM: begin
            if (mem_ready)
               nxt_st = S_WB;
            else if (wait_cnt == WAIT_LAST)
               nxt_st = S_TRAP;
            else
               nxt_wait = wait_cnt + 8'd1;
         end
         S_WB:      nxt_st = S_FETCH;
         default:   nxt_st = S_TRAP;
      endcase
   end

   // Outputs are decoded from the next state so the registered copies track the
   // state register exactly, keeping them Moore with no input-to-output path.
   always_comb begin
      d_ir_wr   = (nxt_st == S_FETCH);
      d_reg_rd  = (nxt_st == S_DECODE);
      d_mem_rd  = (nxt_st == S_MEM) && (nxt_op == OP_LOAD);
      d_mem_wr  = (nxt_st == S_MEM) && (nxt_op == OP_STORE);
      d_pc_wr   = (nxt_st == S_WB);
      d_reg_wr  = (nxt_st == S_WB) && (nxt_op != OP_STORE);
      d_s_mux_c = ((nxt_st == S_WB) && (nxt_op == OP_LOAD)) ? 2'b01 : 2'b00;
      d_illegal = (nxt_st == S_TRAP);
      d_s_mux_b = 2'b00;
      if ((nxt_st == S_EXECUTE) || (nxt_st == S_MEM)) begin
         if (nxt_op == OP_STORE)
            d_s_mux_b = 2'b10;
         else if (nxt_op != OP_R)
            d_s_mux_b = 2'b01;
      end
   end

   // ir_wr is a pure FETCH decode, so it is already high in the reset state.
   always_ff @(posedge clk) begin
      if (rst) begin
         st       <= S_FETCH;
         op_q     <= 7'd0;
         wait_cnt <= 8'd0;
         retired  <= '0;
         ir_wr    <= 1'b1;
         reg_rd   <= 1'b0;
         mem_rd   <= 1'b0;
         mem_wr   <= 1'b0;
         pc_wr    <= 1'b0;
         reg_wr   <= 1'b0;
         s_mux_b  <= 2'b00;
         s_mux_c  <= 2'b00;
         illegal  <= 1'b0;
      end else begin
         st       <= nxt_st;
         op_q     <= nxt_op;
         wait_cnt <= nxt_wait;
         if (st == S_WB)
            retired <= retired + 1'b1;
         ir_wr    <= d_ir_wr;
         reg_rd   <= d_reg_rd;
         mem_rd   <= d_mem_rd;
         mem_wr   <= d_mem_wr;
         pc_wr    <= d_pc_wr;
         reg_wr   <= d_reg_wr;
         s_mux_b  <= d_s_mux_b;
         s_mux_c  <= d_s_mux_c;
         illegal  <= d_illegal;
      end
   end

   assign state = st;

endmodule
